// File: rtl/shift_sequencer.sv
// Purpose : multi-cycle shifter; iterates a 1-bit shift stage (pass/LSL/LSR/ASR) up to 15 times.
// Latency : N+1 edges from accepted start to done (1 edge when amount==0 or op==pass).
// Backpressure: one shift in flight; ready low while shifting, start ignored then; abort cancels.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, abort        request (taken when ready) / cancel (wins over start)
//   in[15:0], shift[1:0], amount[3:0]   operand, operation, step count (latched on accept)
//   ready, busy, done   state decodes; done is a one-cycle completion pulse
//   sout[15:0]          result register, held until the next completion
module shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] in,
    input  logic [1:0]  shift,
    input  logic [3:0]  amount,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] sout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] acc, acc_nxt;
    logic [1:0]  op, op_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] sout_nxt;
    logic [15:0] step;

    // Single-bit shift stage using the datapath shifter's operation encoding.
    always_comb begin
        step = acc;
        case (op)
            2'b00:   step = acc;
            2'b01:   step = {acc[14:0], 1'b0};
            2'b10:   step = {1'b0, acc[15:1]};
            default: step = {acc[15], acc[15:1]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        op_nxt    = op;
        cnt_nxt   = cnt;
        sout_nxt  = sout;

        if (abort) begin
            // Cancel: drop whatever is in flight, keep the previous result.
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state_nxt = ST_IDLE;
                    if (start) begin
                        // Zero steps or pass: result is the operand, no SHIFT cycles.
                        if (amount == 4'd0 || shift == 2'b00) begin
                            sout_nxt  = in;
                            state_nxt = ST_DONE;
                        end else begin
                            acc_nxt   = in;
                            op_nxt    = shift;
                            cnt_nxt   = amount;
                            state_nxt = ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // cnt is always >= 1 here, so the decrement cannot wrap.
                    acc_nxt = step;
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        sout_nxt  = step;
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= 16'h0000;
            op    <= 2'b00;
            cnt   <= 4'd0;
            sout  <= 16'h0000;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            op    <= op_nxt;
            cnt   <= cnt_nxt;
            sout  <= sout_nxt;
        end
    end

    assign ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy  = (state == ST_SHIFT);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] in;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sout;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_q[$];

    typedef struct {
        logic [15:0] din;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] exp;
        int          n;
    } vec_t;

    vec_t vecs[9];

    shift_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .in     (in),
        .shift  (shift),
        .amount (amount),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .sout   (sout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 sout=%h", sout);
            end else begin
                chk("sout", sout, sb_q.pop_front());
            end
        end
    end

    // Wait for done with a cycle budget; returns edges counted since accept edge.
    task automatic wait_done(input int edges_in, input int busy_in, output int edges, output int bcnt);
        edges = edges_in;
        bcnt  = busy_in;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) bcnt++;
            tick();
            edges++;
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int edges, bcnt;
        in = v.din; shift = v.op; amount = v.amt; start = 1'b1;
        sb_q.push_back(v.exp);
        tick();
        start = 1'b0;
        in = 16'($urandom); shift = 2'($urandom); amount = 4'($urandom);
        wait_done(1, 0, edges, bcnt);
        chk({tag, "_latency"}, 16'(edges), 16'(v.n + 1));
        chk({tag, "_busy_cycles"}, 16'(bcnt), 16'(v.n));
        tick();
        chk({tag, "_done_one_cycle"}, {15'd0, done}, 16'd0);
        chk({tag, "_ready_after"}, {15'd0, ready}, 16'd1);
    endtask

    initial begin
        int edges, bcnt;
        vecs[0] = '{16'h8001, 2'b11, 4'd3,  16'hF000, 3};
        vecs[1] = '{16'h0001, 2'b01, 4'd15, 16'h8000, 15};
        vecs[2] = '{16'hF0F0, 2'b10, 4'd4,  16'h0F0F, 4};
        vecs[3] = '{16'hF0F0, 2'b10, 4'd0,  16'hF0F0, 0};
        vecs[4] = '{16'h1234, 2'b00, 4'd7,  16'h1234, 0};
        vecs[5] = '{16'h7FFE, 2'b11, 4'd2,  16'h1FFF, 2};
        vecs[6] = '{16'h8000, 2'b11, 4'd15, 16'hFFFF, 15};
        vecs[7] = '{16'h8000, 2'b10, 4'd15, 16'h0001, 15};
        vecs[8] = '{16'hABCD, 2'b01, 4'd1,  16'h579A, 1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        in = 16'h0; shift = 2'b00; amount = 4'd0;
        tick(); tick();
        chk("rst_ready", {15'd0, ready}, 16'd1);
        chk("rst_busy",  {15'd0, busy},  16'd0);
        chk("rst_done",  {15'd0, done},  16'd0);
        chk("rst_sout",  sout, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Intermediate ASR values 0x8001 >>> 1,2.
        in = 16'h8001; shift = 2'b11; amount = 4'd3; start = 1'b1;
        sb_q.push_back(16'hF000);
        tick(); start = 1'b0;
        tick(); chk("asr_step1", dut.acc, 16'hC000);
        tick(); chk("asr_step2", dut.acc, 16'hE000);
        wait_done(3, 0, edges, bcnt);
        tick();

        for (int i = 0; i < 9; i++) run(vecs[i], $sformatf("vec%0d", i));

        // start during SHIFT is ignored.
        in = 16'h00FF; shift = 2'b01; amount = 4'd8; start = 1'b1;
        sb_q.push_back(16'hFF00);
        tick(); start = 1'b0;
        tick(); tick();
        in = 16'h1234; shift = 2'b10; amount = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        wait_done(4, 3, edges, bcnt);
        chk("ignore_latency", 16'(edges), 16'd9);
        chk("ignore_busy", 16'(bcnt), 16'd8);
        tick();

        // abort after 2 steps: no done, sout held.
        in = 16'h1111; shift = 2'b01; amount = 4'd8; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("abort_ready", {15'd0, ready}, 16'd1);
        chk("abort_busy",  {15'd0, busy},  16'd0);
        chk("abort_done",  {15'd0, done},  16'd0);
        chk("abort_sout",  sout, 16'hFF00);
        for (int i = 0; i < 10; i++) tick();

        // abort with start in the same IDLE cycle: start ignored.
        in = 16'h5555; shift = 2'b00; amount = 4'd0; start = 1'b1; abort = 1'b1;
        tick(); start = 1'b0; abort = 1'b0;
        chk("abort_start_done", {15'd0, done}, 16'd0);
        chk("abort_start_sout", sout, 16'hFF00);

        // Back-to-back: second request accepted during DONE.
        in = 16'h4000; shift = 2'b11; amount = 4'd1; start = 1'b1;
        sb_q.push_back(16'h2000);
        tick(); start = 1'b0;
        tick();
        chk("b2b_first_done", {15'd0, done}, 16'd1);
        in = 16'h0003; shift = 2'b01; amount = 4'd2; start = 1'b1;
        sb_q.push_back(16'h000C);
        tick(); start = 1'b0;
        chk("b2b_no_bubble", {15'd0, busy}, 16'd1);
        wait_done(1, 0, edges, bcnt);
        chk("b2b_latency", 16'(edges), 16'd3);
        tick();

        // Reset during step 5 of LSR 0xFFFF by 10.
        in = 16'hFFFF; shift = 2'b10; amount = 4'd10; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_done", {15'd0, done}, 16'd0);
        chk("midrst_sout", sout, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("midrst_ready", {15'd0, ready}, 16'd1);
        for (int i = 0; i < 12; i++) tick();

        chk("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
